sdram_host_arbiter: RTL and testbench

Two-port arbiter that shares the single host interface of sdram_controller (wr_*/rd_*/busy) between two requesters: port A (SPI2 memory bridge) and port B (internal master, e.g. DMA/test engine).
- Serialises accesses: one transaction is outstanding at a time.
- Round-robin fairness between A and B.
- Drives the controller's one-cycle enable strobes.
- Returns read data, or a timeout error, to the granted port.

---
 rtl/sdram_host_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sdram_host_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_host_arbiter
//
// Shares the single host interface of sdram_controller between two
// requesters. Port A is the SPI2 memory bridge. Port B is an internal master
// such as a DMA or test engine. One transaction is outstanding at a time.
// Arbitration is round-robin. Completion (read data or a read timeout) goes
// back to the port that was granted.
//
// Ports
//   clk, rst_n            system clock (shared with the controller), async
//                         active-low reset
//   a_req/a_we/a_addr/    port A request, direction, address, write data
//   a_wdata
//   a_ack/a_rdata/a_err   port A completion pulse, read data, timeout flag
//   b_*                   identical set for port B
//   wr_addr/wr_data/      controller write command and one-cycle strobe
//   wr_enable
//   rd_addr/rd_enable     controller read command and one-cycle strobe
//   rd_data/rd_ready      controller read return (rd_data valid with rd_ready)
//   busy                  controller cannot accept a command
//   dbg_state             current FSM state, for observation only
//
// Requester handshake: a port raises req and keeps we/addr/wdata stable until
// it samples its ack high. It drops req on that same clock edge. ack is a
// single-cycle pulse. rdata and err are meaningful in the ack cycle and hold
// until the same port completes again. If req falls before ack, the latched
// transaction still runs to completion and still acks.
// ---------------------------------------------------------------------------
module sdram_host_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 16,
    parameter int RD_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,

    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_enable,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    input  logic              busy,

    output logic [2:0]        dbg_state
);

    localparam int CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_GUARD   = 3'd2,
        S_WAIT_WR = 3'd3,
        S_WAIT_RD = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t             state;
    logic               last_grant_b;   // 1: B was granted most recently
    logic               gnt_b;          // port owning the current transaction
    logic               lat_we;         // direction of the current transaction
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               grant_b;

    // On a tie, the port that did not win last time goes first.
    always_comb begin
        grant_b  = (a_req && b_req) ? ~last_grant_b : b_req;
        cnt_next = cnt + CNT_W'(1);
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            last_grant_b <= 1'b1;
            gnt_b        <= 1'b0;
            lat_we       <= 1'b0;
            cnt          <= '0;
            a_ack        <= 1'b0;
            a_rdata      <= '0;
            a_err        <= 1'b0;
            b_ack        <= 1'b0;
            b_rdata      <= '0;
            b_err        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_enable    <= 1'b0;
            rd_addr      <= '0;
            rd_enable    <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses unless set below.
            wr_enable <= 1'b0;
            rd_enable <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!busy && (a_req || b_req)) begin
                        gnt_b        <= grant_b;
                        last_grant_b <= grant_b;
                        lat_we       <= grant_b ? b_we : a_we;
                        // The command registers double as the request latch,
                        // so they hold until the next grant.
                        wr_addr      <= grant_b ? b_addr  : a_addr;
                        rd_addr      <= grant_b ? b_addr  : a_addr;
                        wr_data      <= grant_b ? b_wdata : a_wdata;
                        wr_enable    <= grant_b ? b_we    : a_we;
                        rd_enable    <= grant_b ? ~b_we   : ~a_we;
                        state        <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    state <= S_GUARD;
                end

                // The controller raises busy one cycle after the strobe;
                // skipping this cycle keeps WAIT_WR from seeing a stale low.
                S_GUARD: begin
                    cnt   <= '0;
                    state <= lat_we ? S_WAIT_WR : S_WAIT_RD;
                end

                S_WAIT_WR: begin
                    if (!busy) begin
                        if (gnt_b) begin
                            b_ack <= 1'b1;
                            b_err <= 1'b0;
                        end else begin
                            a_ack <= 1'b1;
                            a_err <= 1'b0;
                        end
                        state <= S_DONE;
                    end
                end

                // rd_ready is checked first so it wins over a timeout that
                // expires in the same cycle.
                S_WAIT_RD: begin
                    if (rd_ready) begin
                        if (gnt_b) begin
                            b_ack   <= 1'b1;
                            b_err   <= 1'b0;
                            b_rdata <= rd_data;
                        end else begin
                            a_ack   <= 1'b1;
                            a_err   <= 1'b0;
                            a_rdata <= rd_data;
                        end
                        state <= S_DONE;
                    end else if (cnt_next == CNT_W'(RD_TIMEOUT)) begin
                        if (gnt_b) begin
                            b_ack <= 1'b1;
                            b_err <= 1'b1;
                        end else begin
                            a_ack <= 1'b1;
                            a_err <= 1'b1;
                        end
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt_next;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_host_arbiter
//
// Testbench for sdram_host_arbiter. It contains two requester drivers, a
// behavioural controller model, and a transaction-level reference. At each
// grant the reference picks the winning port by the round-robin rule and
// predicts the command the controller should see. From the controller model's
// response delay it also predicts the completion cycle, ack port, err and
// rdata.
//
// Everything runs from one process on the falling edge:
//   check outputs -> drive controller -> drive ports -> arbitration model.
// ---------------------------------------------------------------------------
module tb_sdram_host_arbiter;

  localparam int AW = 32;
  localparam int DW = 16;
  localparam int T  = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_ack, a_err;
  logic [DW-1:0] a_rdata;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_ack, b_err;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data = '0;
  logic          wr_enable, rd_enable;
  logic          rd_ready = 1'b0, busy = 1'b0;
  logic [2:0]    dbg_state;

  sdram_host_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data),
    .rd_ready(rd_ready), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          a_script[$];
  txn_t          b_script[$];
  logic [31:0]   exp_q[$];            // expected grant order, by address
  logic [DW-1:0] mem [logic [AW-1:0]];

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  // reference model
  logic          in_flight = 1'b0;
  logic          exp_strobe = 1'b0;
  logic          exp_port_b = 1'b0;
  logic          exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic          exp_err = 1'b0;
  logic [DW-1:0] exp_rdata = '0;
  logic          last_b = 1'b1;
  logic [DW-1:0] a_rdata_m = '0, b_rdata_m = '0;
  int            ack_cyc = 0;
  int            idle_from = 0;
  int            strobe_cyc = 0;

  // controller model
  int            busy_until = -1;
  int            rd_at = -1;
  int            refresh_left = 0;
  int            rd_mode = 3;         // 0 random, 1 never, 2 last legal cycle, 3 prompt
  logic [AW-1:0] ctrl_addr = '0;
  logic          force_busy = 1'b0;
  logic          refresh_en = 1'b0;
  logic          stray_en = 1'b0;

  // port drivers
  logic          p_auto[2] = '{1'b0, 1'b0};
  int            p_gap[2] = '{0, 0};

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] addr);
    if (mem.exists(addr)) return mem[addr];
    return addr[DW-1:0] ^ 16'h5A5A;
  endfunction

  // A command reached the controller: predict how and when it completes.
  task automatic on_strobe();
    int l;
    int d;
    int r;
    logic ok;
    strobe_cyc = cyc;
    in_flight  = 1'b1;
    if (exp_we) begin
      mem[exp_addr] = exp_wdata;
      l = int'($urandom_range(0, 5));
      busy_until = cyc + l;
      // Busy seen only during GUARD is absorbed; otherwise done the cycle after it ends.
      ack_cyc = cyc + ((l > 1) ? l : 1) + 2;
      exp_err = 1'b0;
    end else begin
      case (rd_mode)
        1: d = 0;
        2: d = T + 1;
        3: d = int'($urandom_range(2, 6));
        default: begin
          r = int'($urandom_range(0, 9));
          if (r < 6)       d = int'($urandom_range(2, 6));
          else if (r == 6) d = T + 1;
          else if (r == 7) d = 1;            // lands in GUARD, ignored
          else if (r == 8) d = 0;            // never answers
          else             d = int'($urandom_range(2, T + 1));
        end
      endcase
      // WAIT_RD spans strobe+2 .. strobe+T+1; a pulse there completes the read.
      ok = (d >= 2) && (d <= T + 1);
      rd_at = (d > 0) ? cyc + d : -1;
      ctrl_addr = exp_addr;
      busy_until = cyc + int'($urandom_range(0, 3));
      ack_cyc = ok ? cyc + d + 1 : cyc + T + 2;
      exp_err = ~ok;
      exp_rdata = mem_rd(exp_addr);
    end
  endtask

  task automatic check_outputs();
    logic strobe;
    logic done_now;
    logic exp_a;
    logic exp_b;
    strobe = wr_enable | rd_enable;
    if (strobe) check("enable_overlap", 32'(wr_enable & rd_enable), 32'(0));
    if (strobe || exp_strobe) check("strobe", 32'(strobe), 32'(exp_strobe));
    if (strobe && exp_strobe) begin
      check("strobe_we", 32'(wr_enable), 32'(exp_we));
      check("strobe_addr", exp_we ? wr_addr : rd_addr, exp_addr);
      if (exp_we) check("strobe_wdata", 32'(wr_data), 32'(exp_wdata));
      if (exp_q.size() > 0) check("grant_order", exp_we ? wr_addr : rd_addr, exp_q.pop_front());
      on_strobe();
    end
    exp_strobe = 1'b0;

    done_now = in_flight && (cyc == ack_cyc);
    exp_a = done_now && !exp_port_b;
    exp_b = done_now && exp_port_b;
    if (a_ack || exp_a) check("a_ack", 32'(a_ack), 32'(exp_a));
    if (b_ack || exp_b) check("b_ack", 32'(b_ack), 32'(exp_b));
    if (done_now) begin
      if (!exp_we && !exp_err) begin
        if (exp_port_b) b_rdata_m = exp_rdata;
        else            a_rdata_m = exp_rdata;
      end
      check(exp_port_b ? "b_err" : "a_err", 32'(exp_port_b ? b_err : a_err), 32'(exp_err));
      check("a_rdata", 32'(a_rdata), 32'(a_rdata_m));
      check("b_rdata", 32'(b_rdata), 32'(b_rdata_m));
      in_flight = 1'b0;
      idle_from = cyc + 1;
      rd_at = -1;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_ctrl();
    rd_ready = (cyc == rd_at);
    if (!in_flight && stray_en && $urandom_range(0, 7) == 0) rd_ready = 1'b1;
    rd_data = (cyc == rd_at) ? mem_rd(ctrl_addr) : DW'($urandom);
    if (!in_flight && refresh_en && refresh_left == 0 && $urandom_range(0, 15) == 0)
      refresh_left = int'($urandom_range(1, 6));
    busy = force_busy || (cyc > strobe_cyc && cyc <= busy_until) || (refresh_left > 0);
    if (refresh_left > 0) refresh_left--;
  endtask

  task automatic next_txn(input int p, output logic have, output txn_t t);
    have = 1'b0;
    t.we = 1'b0;
    t.addr = '0;
    t.data = '0;
    if (p == 0 && a_script.size() > 0) begin
      t = a_script.pop_front();
      have = 1'b1;
    end else if (p == 1 && b_script.size() > 0) begin
      t = b_script.pop_front();
      have = 1'b1;
    end else if (p_auto[p]) begin
      if (p_gap[p] > 0) p_gap[p]--;
      else begin
        have = 1'b1;
        t.we = 1'($urandom_range(0, 1));
        t.addr = AW'($urandom_range(0, 15));
        t.data = DW'($urandom);
      end
    end
  endtask

  task automatic drive_ports();
    logic have;
    txn_t t;
    if (a_req && a_ack) begin
      a_req = 1'b0;
      p_gap[0] = int'($urandom_range(0, 3));
    end else if (!a_req) begin
      next_txn(0, have, t);
      if (have) begin a_req = 1'b1; a_we = t.we; a_addr = t.addr; a_wdata = t.data; end
    end
    if (b_req && b_ack) begin
      b_req = 1'b0;
      p_gap[1] = int'($urandom_range(0, 3));
    end else if (!b_req) begin
      next_txn(1, have, t);
      if (have) begin b_req = 1'b1; b_we = t.we; b_addr = t.addr; b_wdata = t.data; end
    end
  endtask

  // Arbitration reference: who should win the inputs just applied.
  task automatic arbitrate();
    logic pb;
    if (!in_flight && !exp_strobe && cyc >= idle_from && !busy && (a_req || b_req)) begin
      pb = (a_req && b_req) ? ~last_b : b_req;
      last_b = pb;
      exp_strobe = 1'b1;
      exp_port_b = pb;
      exp_we = pb ? b_we : a_we;
      exp_addr = pb ? b_addr : a_addr;
      exp_wdata = pb ? b_wdata : a_wdata;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check_outputs();
    drive_ctrl();
    drive_ports();
    arbitrate();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_wr_enable", 32'(wr_enable), 32'(0));
    check("rst_rd_enable", 32'(rd_enable), 32'(0));
    check("rst_a_ack", 32'(a_ack), 32'(0));
    check("rst_b_ack", 32'(b_ack), 32'(0));
    check("rst_a_err", 32'(a_err), 32'(0));
    check("rst_b_err", 32'(b_err), 32'(0));
    check("rst_a_rdata", 32'(a_rdata), 32'(0));
    check("rst_b_rdata", 32'(b_rdata), 32'(0));
    check("rst_wr_addr", wr_addr, 32'(0));
    check("rst_wr_data", 32'(wr_data), 32'(0));
    check("rst_rd_addr", rd_addr, 32'(0));
    in_flight = 1'b0;
    exp_strobe = 1'b0;
    last_b = 1'b1;
    a_rdata_m = '0;
    b_rdata_m = '0;
    busy_until = -1;
    rd_at = -1;
    refresh_left = 0;
    idle_from = 0;
    rd_ready = 1'b0;
    busy = force_busy;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    drive_ctrl();
    drive_ports();
    arbitrate();
  endtask

  task automatic run_until_quiet(input int max_cyc);
    int n;
    n = 0;
    while ((a_req || b_req || in_flight || exp_strobe || a_script.size() > 0 ||
            b_script.size() > 0) && n < max_cyc) begin
      tick();
      n++;
    end
    check("quiet", 32'(a_req | b_req | in_flight | exp_strobe), 32'(0));
  endtask

  task automatic wait_in_flight();
    int n;
    n = 0;
    while (!in_flight && n < 40) begin
      tick();
      n++;
    end
    check("in_flight", 32'(in_flight), 32'(1));
  endtask

  task automatic push_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data;
    a_script.push_back(t);
  endtask

  task automatic push_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data;
    b_script.push_back(t);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Controller busy through and after reset: nothing may issue until it drops.
    force_busy = 1'b1;
    do_reset();
    push_a(1'b1, 32'h0, 16'hABCD);
    exp_q.push_back(32'h0);
    repeat (100) tick();
    force_busy = 1'b0;
    run_until_quiet(50);

    // Write then read back through port A.
    rd_mode = 3;
    push_a(1'b1, 32'h0A, 16'hEF01);
    push_a(1'b0, 32'h0A, 16'h0);
    run_until_quiet(100);
    check("t2_a_rdata", 32'(a_rdata), 32'h0000EF01);
    check("t2_a_err", 32'(a_err), 32'(0));

    // Both ports requesting continuously from reset: A, B, A, B.
    push_a(1'b1, 32'h100, 16'h1111);
    push_a(1'b0, 32'h101, 16'h0);
    push_b(1'b1, 32'h200, 16'h2222);
    push_b(1'b0, 32'h201, 16'h0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h101);
    exp_q.push_back(32'h201);
    do_reset();
    run_until_quiet(200);

    // B read that never returns: error, rdata held; then A is served normally.
    push_b(1'b0, 32'h0A, 16'h0);
    run_until_quiet(100);
    rd_mode = 1;
    push_b(1'b0, 32'h0B, 16'h0);
    run_until_quiet(100);
    check("t4_b_err", 32'(b_err), 32'(1));
    check("t4_b_rdata", 32'(b_rdata), 32'h0000EF01);
    rd_mode = 3;
    push_a(1'b1, 32'h20, 16'h1234);
    run_until_quiet(100);

    // rd_ready on the last legal cycle wins over the timeout.
    rd_mode = 2;
    push_a(1'b0, 32'h20, 16'h0);
    run_until_quiet(100);
    check("t5_a_rdata", 32'(a_rdata), 32'h00001234);
    check("t5_a_err", 32'(a_err), 32'(0));

    // Stray rd_ready pulses while idle.
    stray_en = 1'b1;
    repeat (30) tick();
    stray_en = 1'b0;

    // Reset during WAIT_RD with only B pending: B is served after release.
    rd_mode = 1;
    push_b(1'b0, 32'h30, 16'h0);
    wait_in_flight();
    repeat (4) tick();
    do_reset();
    rd_mode = 3;
    exp_q.push_back(32'h30);
    run_until_quiet(100);

    // Reset during WAIT_RD with both pending: A first, then B.
    rd_mode = 1;
    push_b(1'b0, 32'h31, 16'h0);
    wait_in_flight();
    push_a(1'b1, 32'h40, 16'h5555);
    repeat (4) tick();
    do_reset();
    rd_mode = 3;
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h31);
    run_until_quiet(100);

    // Random traffic with refresh busy, stray pulses and mixed read latencies.
    rd_mode = 0;
    refresh_en = 1'b1;
    stray_en = 1'b1;
    p_auto[0] = 1'b1;
    p_auto[1] = 1'b1;
    repeat (3000) tick();
    p_auto[0] = 1'b0;
    p_auto[1] = 1'b0;
    refresh_en = 1'b0;
    stray_en = 1'b0;
    run_until_quiet(200);

    check("grant_order_left", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
